// File: rtl/riscv_div_iter_pkg.sv
// riscv_div_iter_pkg: ALU div/rem encodings, decode bit positions and divider state type
package riscv_div_iter_pkg;
  localparam int ALU_OP_WIDTH = 7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;
  localparam int DIV_SIGNED_BIT = 0;
  localparam int DIV_REM_BIT = 1;
  typedef enum logic [1:0] {DIV_IDLE, DIV_ITER, DIV_FIX, DIV_DONE} div_state_t;
endpackage

// File: rtl/riscv_div_iter_clz.sv
// riscv_div_clz: combinational leading-zero count, all-zero input yields WIDTH
module riscv_div_clz #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) count = data[i] ? CNT_W'(WIDTH - 1 - i) : count;
  end
endmodule

// File: rtl/riscv_div_iter.sv
// riscv_div_iter: iterative radix-2 div/rem unit; RISCV_DIV_EARLY_OUT_EN skips leading dividend zeros
module riscv_div_iter
  import riscv_div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_OP_WIDTH-1:0] operator_i,
  input  logic [WIDTH-1:0]        op_a_i,
  input  logic [WIDTH-1:0]        op_b_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        result_o,
  output logic                    valid_o,
  input  logic                    ready_i
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  div_state_t state, state_n;
  logic [CNT_W-1:0] cnt, iters;
  logic [WIDTH-1:0] rem, quo, div, abs_a, abs_b, dvd, fix_res;
  logic [WIDTH:0] trial;
  logic sgn, rem_op, a_neg, b_neg, sign_q, sign_r, is_rem, accept, div0, ovf, unused_op;
  assign unused_op = ^operator_i[ALU_OP_WIDTH-1:2];
  assign sgn = operator_i[DIV_SIGNED_BIT];
  assign rem_op = operator_i[DIV_REM_BIT];
  assign a_neg = sgn & op_a_i[WIDTH-1];
  assign b_neg = sgn & op_b_i[WIDTH-1];
  assign abs_a = a_neg ? -op_a_i : op_a_i;
  assign abs_b = b_neg ? -op_b_i : op_b_i;
  assign div0 = op_b_i == '0;
  assign ovf = sgn && op_a_i == {1'b1, {(WIDTH-1){1'b0}}} && &op_b_i;
  assign ready_o = state == DIV_IDLE;
  assign valid_o = state == DIV_DONE;
  assign accept = valid_i & ready_o & ~flush_i;
`ifdef RISCV_DIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;
  riscv_div_clz #(.WIDTH(WIDTH)) u_clz (.data(abs_a), .count(lz));
  assign dvd = abs_a << lz;
  assign iters = (lz == CNT_W'(WIDTH)) ? CNT_W'(1) : CNT_W'(WIDTH) - lz;
`else
  assign dvd = abs_a;
  assign iters = CNT_W'(WIDTH);
`endif
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, div};
  assign fix_res = is_rem ? (sign_r ? -rem : rem) : (sign_q ? -quo : quo);
  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: state_n = accept ? ((div0 | ovf) ? DIV_DONE : DIV_ITER) : DIV_IDLE;
      DIV_ITER: state_n = (cnt == CNT_W'(1)) ? DIV_FIX : DIV_ITER;
      DIV_FIX:  state_n = DIV_DONE;
      DIV_DONE: state_n = ready_i ? DIV_IDLE : DIV_DONE;
      default:  state_n = DIV_IDLE;
    endcase
    if (flush_i) state_n = DIV_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_o <= '0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      div <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      if (accept) begin
        rem <= '0;
        quo <= dvd;
        div <= abs_b;
        cnt <= iters;
        sign_q <= a_neg ^ b_neg;
        sign_r <= a_neg;
        is_rem <= rem_op;
        if (div0 | ovf) result_o <= div0 ? (rem_op ? op_a_i : '1) : (rem_op ? '0 : op_a_i);
      end
      if (state == DIV_ITER) begin
        rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        cnt <= cnt - CNT_W'(1);
      end
      if (state == DIV_FIX) result_o <= fix_res;
    end
  end
endmodule

// File: tb/tb_riscv_div_iter.sv
// tb_riscv_div_iter: randomized and directed div/rem checks against an arithmetic model
module tb_riscv_div_iter;
  import riscv_div_iter_pkg::*;
  localparam int W = 32;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
`ifdef RISCV_DIV_EARLY_OUT_EN
  localparam int LAT_100_7 = 9;
`else
  localparam int LAT_100_7 = W + 2;
`endif
  typedef struct {logic [W-1:0] res; int lat; int acc;} exp_t;
  logic clk = 0, rst = 1, valid_i = 0, flush_i = 0, ready_i = 1, ready_o, valid_o;
  logic [ALU_OP_WIDTH-1:0] operator_i = ALU_DIVU;
  logic [W-1:0] op_a_i = '0, op_b_i = '0, result_o, held;
  exp_t exp_q[$];
  exp_t e;
  int tests = 0, failed = 0, ncyc = 0;
  bit holding = 0, rand_rdy = 0;
  always #5 clk = ~clk;
  riscv_div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .operator_i(operator_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i), .result_o(result_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, ncyc);
    end
  endtask
  function automatic logic [W-1:0] model(input logic [ALU_OP_WIDTH-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return op[1] ? a : '1;
    if (op[0]) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = a;
      sb = b;
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? W'(r) : W'(q);
  endfunction
  function automatic int exp_lat(input logic [ALU_OP_WIDTH-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef RISCV_DIV_EARLY_OUT_EN
    logic [W-1:0] m;
    int n;
`endif
    if (b == '0 || (op[0] && a == MINV && b == '1)) return 1;
`ifdef RISCV_DIV_EARLY_OUT_EN
    m = (op[0] && a[W-1]) ? -a : a;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return n + 2;
`else
    return W + 2;
`endif
  endfunction
  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      if (valid_o) begin
        check("busy_ready", W'(ready_o), '0);
        if (!holding) begin
          if (exp_q.size() == 0) check("spurious_valid", W'(valid_o), '0);
          else begin
            e = exp_q.pop_front();
            check("result", result_o, e.res);
            check("latency", W'(ncyc - e.acc), W'(e.lat));
            held = result_o;
            holding = 1;
          end
        end else check("hold_stable", result_o, held);
      end else begin
        holding = 0;
        check("ready", W'(ready_o), W'(exp_q.size() == 0));
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  end
  task automatic issue(input logic [ALU_OP_WIDTH-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!ready_o && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", W'(ready_o), W'(1));
    operator_i = op;
    op_a_i = a;
    op_b_i = b;
    valid_i = 1;
    @(posedge clk);
    exp_q.push_back('{model(op, a, b), exp_lat(op, a, b), ncyc});
    #1 valid_i = 0;
    op_a_i = $urandom;
    op_b_i = $urandom;
    operator_i = ALU_DIVU | ALU_OP_WIDTH'($urandom_range(0, 3));
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || valid_o) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", W'(t < 500), W'(1));
  endtask
  logic [ALU_OP_WIDTH-1:0] d_op[8] = '{ALU_DIVU, ALU_DIV, ALU_REM, ALU_REMU, ALU_DIV, ALU_REMU, ALU_DIV, ALU_REM};
  logic [W-1:0] d_a[8] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5, MINV, MINV};
  logic [W-1:0] d_b[8] = '{32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [W-1:0] d_r[8] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd5, MINV, 32'd0};
  initial begin
    int t, lat;
    bit seen;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [W-1:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_result", result_o, '0);
    check("reset_valid", W'(valid_o), '0);
    check("reset_ready", W'(ready_o), W'(1));
    check("pin_lat_100_7", W'(exp_lat(ALU_DIVU, 32'd100, 32'd7)), W'(LAT_100_7));
    check("pin_lat_div0", W'(exp_lat(ALU_DIV, 32'd5, 32'd0)), W'(1));
    for (int i = 0; i < 8; i++) begin
      check("pin_model", model(d_op[i], d_a[i], d_b[i]), d_r[i]);
      issue(d_op[i], d_a[i], d_b[i]);
      drain();
    end
    issue(ALU_DIVU, 32'd100, 32'd7);
    t = 0;
    while (!valid_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("divu_100_7", result_o, 32'd14);
    drain();
    ready_i = 0;
    issue(ALU_DIVU, 32'd1000, 32'd3);
    t = 0;
    while (!valid_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("hold_valid_seen", W'(valid_o), W'(1));
    repeat (5) @(negedge clk);
    check("hold_result", result_o, 32'd333);
    ready_i = 1;
    @(posedge clk);
    @(negedge clk);
    check("release_ready", W'(ready_o), W'(1));
    check("release_valid", W'(valid_o), '0);
    issue(ALU_REMU, 32'd1000, 32'd3);
    drain();
    issue(ALU_DIVU, 32'hFFFFFFFF, 32'd3);
    repeat (10) @(negedge clk);
    flush_i = 1;
    @(posedge clk);
    exp_q.delete();
    #1 flush_i = 0;
    @(negedge clk);
    check("flush_ready", W'(ready_o), W'(1));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= valid_o;
    end
    check("flush_no_valid", W'(seen), '0);
    operator_i = ALU_DIVU;
    op_a_i = 32'd50;
    op_b_i = 32'd5;
    valid_i = 1;
    flush_i = 1;
    @(posedge clk);
    #1 valid_i = 0;
    flush_i = 0;
    @(negedge clk);
    check("flush_blocks_accept", W'(ready_o), W'(1));
    issue(ALU_DIVU, 32'd100, 32'd7);
    lat = exp_lat(ALU_DIVU, 32'd100, 32'd7);
    repeat (lat - 1) @(negedge clk);
    rst = 1;
    @(posedge clk);
    exp_q.delete();
    #1 rst = 0;
    @(negedge clk);
    check("fix_reset_result", result_o, '0);
    check("fix_reset_valid", W'(valid_o), '0);
    check("fix_reset_ready", W'(ready_o), W'(1));
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      op = ALU_DIVU | ALU_OP_WIDTH'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: begin a = MINV; b = '1; end
        3: a = W'($urandom_range(0, 300));
        4: b = {1'b1, W'($urandom) >> 1};
        default: ;
      endcase
      issue(op, a, b);
    end
    rand_rdy = 0;
    #2 ready_i = 1;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, failed);
    $fatal(1);
  end
endmodule
